// File: rtl/bitwise_stream_unit.sv
// Pipelined bitwise operator stream with valid/ready flow control and burst accumulation.
// Ports: clk, reset (async high), in_* beat stream, out_* result stream; optional out_parity (BITWISE_STREAM_PARITY_EN).
module bitwise_stream_unit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
`ifdef BITWISE_STREAM_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int LAST = STAGES - 1;

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [2:0]       op_q;

  logic [WIDTH-1:0] sd [STAGES];
  logic             sv [STAGES];
  logic [WIDTH-1:0] nd [STAGES];
  logic             nv [STAGES];

  logic             advance;
  logic             fire;
  logic             emit;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] res;

  function automatic logic [WIDTH-1:0] bw(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    unique case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = ~a;
      3'd7: r = a;
    endcase
    return r;
  endfunction

  assign out_valid = sv[LAST];
  assign out_data  = sd[LAST];
  assign out_zero  = (sd[LAST] == '0);
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign fire      = in_valid && in_ready;

  // In a burst the running accumulator replaces operand B
  // and the op captured on the first beat stays in force.
  assign op_sel = (state == ACC) ? op_q : in_op;
  assign b_sel  = (state == ACC) ? acc : in_b;
  assign res    = bw(op_sel, in_a, b_sel);

  // Only plain beats and burst-closing beats produce output.
  assign emit = fire &&
    ((state == IDLE) ? (!in_acc || in_last) : in_last);

  assign nv[0] = emit;
  assign nd[0] = emit ? res : '0;

  for (genvar i = 1; i < STAGES; i++) begin : g_chain
    assign nv[i] = sv[i-1];
    assign nd[i] = sd[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        sv[i] <= 1'b0;
        sd[i] <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i < STAGES; i++) begin
        sv[i] <= nv[i];
        sd[i] <= nd[i];
      end
    end
  end

`ifdef BITWISE_STREAM_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_parity <= 1'b0;
    end else if (advance) begin
      out_parity <= ^nd[LAST];
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      op_q  <= 3'd0;
    end else if (fire) begin
      unique case (state)
        IDLE: begin
          if (in_acc && !in_last) begin
            acc   <= res;
            op_q  <= in_op;
            state <= ACC;
          end
        end
        ACC: begin
          if (in_last) begin
            acc   <= '0;
            state <= IDLE;
          end else begin
            acc <= res;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_stream_unit.sv
// Scoreboard bench for bitwise_stream_unit: directed beats push
// expected results; a negedge monitor pops and compares.
module tb_bitwise_stream_unit;

  localparam int W = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         in_acc;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_zero;
`ifdef BITWISE_STREAM_PARITY_EN
  logic         out_parity;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q [$];

  bitwise_stream_unit #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
`ifdef BITWISE_STREAM_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed result is compared with the queue head.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        e = q.pop_front();
        chk("out_data", out_data, e);
        chk("out_zero", {15'd0, out_zero}, {15'd0, (e == '0)});
`ifdef BITWISE_STREAM_PARITY_EN
        chk("out_parity", {15'd0, out_parity}, {15'd0, ^e});
`endif
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic acc,
                      input logic last, input bit emit,
                      input logic [W-1:0] exp);
    int n;
    in_a = a; in_b = b; in_op = op;
    in_acc = acc; in_last = last; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready 0 expected 1");
    end
    if (emit) q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results missing, expected 0", q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic latency_after_send();
    int n;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n[W-1:0], S[W-1:0]);
  endtask

  logic [W-1:0] ops_exp [8];
  logic [W-1:0] hold;
  int           w;

  initial begin
    ops_exp[0] = 16'hF000; ops_exp[1] = 16'hFFF0;
    ops_exp[2] = 16'h0FF0; ops_exp[3] = 16'h0FFF;
    ops_exp[4] = 16'h000F; ops_exp[5] = 16'hF00F;
    ops_exp[6] = 16'h0F0F; ops_exp[7] = 16'hF0F0;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0; in_acc = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_data", out_data, 16'd0);
    chk("rst_zero", {15'd0, out_zero}, 16'd1);
    chk("rst_ready", {15'd0, in_ready}, 16'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset with two beats in flight.
    send(16'h1111, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1, 16'h1111);
    send(16'h2222, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1, 16'h2222);
    reset = 1'b1;
    #1;
    chk("midrst_valid", {15'd0, out_valid}, 16'd0);
    chk("midrst_data", out_data, 16'd0);
    chk("midrst_zero", {15'd0, out_zero}, 16'd1);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(16'h5A5A, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1, 16'h5A5A);
    latency_after_send();
    drain();

    // All eight ops back to back.
    for (int i = 0; i < 8; i++)
      send(16'hF0F0, 16'hFF00, i[2:0], 1'b0, 1'b0, 1'b1, ops_exp[i]);
    drain();

    // Backpressure: 3-cycle stall after first result.
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(16'h0100 + i[W-1:0], 16'h0, 3'd7, 1'b0, 1'b0, 1'b1,
               16'h0100 + i[W-1:0]);
      end
      begin
        w = 0;
        while (!out_valid && w < 20) begin
          @(posedge clk);
          #1;
          w++;
        end
        out_ready = 1'b0;
        hold = out_data;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_ready", {15'd0, in_ready}, 16'd0);
          chk("stall_data", out_data, hold);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // OR bursts.
    send(16'h0001, 16'hFFFF, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0);
    send(16'h0010, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0);
    send(16'h0100, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    drain();
    send(16'h0001, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0);
    send(16'h0010, 16'hFFFF, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0);
    send(16'h0100, 16'hFFFF, 3'd1, 1'b1, 1'b1, 1'b1, 16'h0111);
    drain();

    // XOR burst with op change ignored; single-beat AND burst.
    send(16'h00FF, 16'h0F0F, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0);
    send(16'hFFFF, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 16'hF00F);
    send(16'h1234, 16'hFFFF, 3'd0, 1'b1, 1'b1, 1'b1, 16'h1234);
    drain();

    // Parity / zero patterns.
    send(16'h0007, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1, 16'h0007);
    send(16'h0003, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1, 16'h0003);
    send(16'h0000, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1, 16'h0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bitwise_stream_unit.md
Name: bitwise_stream_unit

Overview:
- Parametrised, pipelined successor to the fixed 16-bit bitwise gates.
- Applies one of eight bitwise operations to WIDTH-bit operand pairs.
- Adds valid/ready flow control, a configurable pipeline depth, and a burst-accumulate (reduction) mode.
- Sits between a producer stream (e.g. memory read path) and a consumer that needs masked, merged or reduced words.

Parameters:
- WIDTH, 16, operand and result width in bits, 1..64
- STAGES, 2, pipeline register stages from accept to output, 1..4

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  input beat present
- in_ready  output  1  unit can accept a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  operation select
- in_acc  input  1  beat starts an accumulate burst
- in_last  input  1  final beat of an accumulate burst
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result
- out_zero  output  1  out_data == 0

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_zero=1, in_ready=1.
  - All stage valids cleared, FSM=IDLE, accumulator=0.
  - Reset mid-burst or mid-stall discards all in-flight data.
- in_op encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (B ignored), 7 PASS A.
- Handshakes:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - Global advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, all stages hold. out_data/out_valid stay stable until consumed.
- Latency: accepted beat that produces output appears at out_valid exactly STAGES cycles later, absent stalls. Throughput is 1 beat/cycle.
- FSM:
  - IDLE, accept with in_acc=0: result op(a,b) enters pipeline valid.
  - IDLE, accept with in_acc=1, in_last=1: single-beat burst; result op(a,b) emitted; stay IDLE.
  - IDLE, accept with in_acc=1, in_last=0: acc := op(a,b); latch op; go ACC; bubble enters pipeline (no output).
  - ACC, accept with in_last=0: acc := op_latched(a,acc); bubble; stay ACC.
  - ACC, accept with in_last=1: result op_latched(a,acc) emitted; acc := 0; go IDLE.
- Sampling in ACC: in_op, in_acc and in_b are ignored in ACC; the op latched at burst start applies to the whole burst.
- Idle cycles: in_valid=0 inserts a bubble and leaves FSM/acc unchanged.
- Width: all operations are purely bitwise at WIDTH bits; no carries; NOT/NAND/NOR/XNOR invert all WIDTH bits.
- out_zero is combinational from the output register.

Optional Feature:
- Macro: BITWISE_STREAM_PARITY_EN.
- Defined: adds output port out_parity (1 bit) = XOR-reduction of out_data, registered alongside it, reset value 0.
- Not defined: port absent; no parity logic.

Test Plan:
- Reset state: assert reset mid-stream with 2 beats in flight -> out_valid=0, out_data=0, out_zero=1 immediately; after release, first new beat emerges STAGES cycles after accept.
- Per-op check: WIDTH=16, a=16'hF0F0, b=16'hFF00, ops 0..7 back-to-back, out_ready=1 -> F000, FFF0, 0FF0, 0FFF, 000F, F00F, 0F0F, F0F0 on consecutive cycles, first at cycle STAGES.
- Backpressure: stream 5 beats, hold out_ready=0 for 3 cycles after the first out_valid -> in_ready=0 during stall, out_data stable, no beat lost or duplicated, order preserved.
- Accumulate OR burst:
  - Beats a = 0001, 0010 with in_acc=1 in_last=0, then 0100 with in_last=1; op=OR; b=FFFF on the first beat only (in_b is ignored after it).
  - Required: exactly one output, FFFF.
  - Repeat with first b=0000 -> exactly one output, 0111.
- Op latching and single-beat burst:
  - XOR burst: a=00FF, b=0F0F starts the burst; in_op=0 is driven on the next beat a=FFFF, in_last=1 -> single output F00F.
  - Single-beat burst a=1234, b=FFFF, op AND, in_acc=1 in_last=1 -> output 1234.
- Parity (BITWISE_STREAM_PARITY_EN defined): out_data 0007 -> out_parity=1; out_data 0003 -> out_parity=0; out_data 0000 -> out_zero=1.
